bytebeat_mixer: RTL and testbench

Multi-channel bytebeat voice generator with per-channel trigger/decay envelopes and a saturating mixer. It drives the `sig` audio sample path on `dspclk`. It generalises the single fixed-formula sketch voice to CHANNELS independent voices. Each voice has its own time counter, selectable waveform mode, rate and envelope, plus a shared noise source.

---
 rtl/bytebeat_pkg.sv | 33 +++
 rtl/bytebeat_channel.sv | 73 +++++++
 rtl/bytebeat_mixer.sv | 86 ++++++++
 tb/tb_bytebeat_mixer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bytebeat_pkg.sv
// Shared types and helpers for the bytebeat mixer: waveform modes, noise LFSR
// constants and a width-parameterised saturation function.
package bytebeat_pkg;

    typedef enum logic [1:0] {
        MODE_SQUARE = 2'd0,
        MODE_SAW    = 2'd1,
        MODE_BEAT   = 2'd2,
        MODE_NOISE  = 2'd3
    } mode_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Wide enough for any legal BITS plus mixer headroom.
    localparam int unsigned SAT_W = 48;

    function automatic logic signed [SAT_W-1:0] saturate(
        input  logic signed [SAT_W-1:0] v,
        input  int unsigned             bits,
        output logic                    clipped
    );
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = signed'((SAT_W'(1) << (bits - 1)) - SAT_W'(1));
        lo = ~hi;
        clipped = (v > hi) || (v < lo);
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/bytebeat_channel.sv
// One bytebeat voice: time counter, trigger/decay envelope and the registered
// enveloped sample for this channel.
module bytebeat_channel
    import bytebeat_pkg::*;
#(
    parameter int unsigned BITS  = 16,
    parameter int unsigned TW    = 32,
    parameter int unsigned ENV_W = 8
) (
    input  logic                   dspclk,
    input  logic                   n_reset,
    input  logic                   sample_tick,
    input  logic                   trig,
    input  logic [1:0]             mode,
    input  logic [3:0]             rate,
    input  logic [ENV_W-1:0]       decay,
    input  logic                   mute,
    input  logic [15:0]            lfsr,
    output logic signed [BITS-1:0] p
);

    localparam int unsigned PW = BITS + ENV_W + 1;

    logic [TW-1:0]           t;
    logic [ENV_W-1:0]        env;
    logic [BITS-1:0]         raw;
    logic [7:0]              beat_a;
    logic [7:0]              beat_b;
    logic [15:0]             beat_full;
    logic signed [BITS-1:0]  s;
    logic signed [PW-1:0]    prod;
    logic signed [BITS-1:0]  p_next;
    logic                    unused_bits;

    always_ff @(posedge dspclk or negedge n_reset) begin
        if (!n_reset) begin
            t   <= '0;
            env <= '0;
        end else if (trig) begin
            t   <= '0;
            env <= '1;
        end else if (sample_tick) begin
            t   <= t + TW'(rate) + TW'(1);
            env <= (env > decay) ? env - decay : '0;
        end
    end

    always_comb begin
        raw       = '0;
        beat_a    = t[7:0];
        beat_b    = t[15:8] | t[16:9];
        beat_full = 16'(beat_a) * 16'(beat_b);
        case (mode_t'(mode))
            MODE_SQUARE: raw = t[11] ? '1 : '0;
            MODE_SAW:    raw = BITS'(t[11:0]) << (BITS - 12);
            MODE_BEAT:   raw = BITS'(beat_full[7:0]) << (BITS - 8);
            MODE_NOISE:  raw = BITS'(lfsr) << (BITS - 16);
            default:     raw = '0;
        endcase
        // Subtracting 2^(BITS-1) from an unsigned BITS value is an MSB flip.
        s      = signed'({~raw[BITS-1], raw[BITS-2:0]});
        prod   = PW'(s) * PW'(signed'({1'b0, env}));
        p_next = mute ? '0 : prod[ENV_W +: BITS];
    end

    assign unused_bits = ^{t >> 17, beat_full[15:8], prod};

    always_ff @(posedge dspclk or negedge n_reset) begin
        if (!n_reset) p <= '0;
        else          p <= p_next;
    end

endmodule

// File: rtl/bytebeat_mixer.sv
// Multi-voice bytebeat generator: shared noise LFSR, per-channel voices,
// saturating mixer and the sample strobe pipeline.
module bytebeat_mixer
    import bytebeat_pkg::*;
#(
    parameter int unsigned BITS     = 16,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned TW       = 32,
    parameter int unsigned ENV_W    = 8
) (
    input  logic                      dspclk,
    input  logic                      n_reset,
    input  logic                      sample_tick,
    input  logic [CHANNELS-1:0]       trig,
    input  logic [2*CHANNELS-1:0]     mode,
    input  logic [4*CHANNELS-1:0]     rate,
    input  logic [ENV_W*CHANNELS-1:0] decay,
    input  logic [CHANNELS-1:0]       mute,
    output logic signed [BITS-1:0]    sig,
    output logic                      sig_valid,
    output logic                      clip
);

    localparam int unsigned MW = BITS + $clog2(CHANNELS) + 1;

    logic [15:0]             lfsr;
    logic                    tick_d1;
    logic                    tick_d2;
    logic signed [BITS-1:0]  p_all [CHANNELS];
    logic signed [MW-1:0]    sum;
    logic signed [SAT_W-1:0] sat;
    logic                    clipped;
    logic                    unused_sat;

    always_ff @(posedge dspclk or negedge n_reset) begin
        if (!n_reset) begin
            lfsr    <= LFSR_SEED;
            tick_d1 <= 1'b0;
            tick_d2 <= 1'b0;
        end else begin
            if (sample_tick) lfsr <= (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : '0);
            tick_d1 <= sample_tick;
            tick_d2 <= tick_d1;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        bytebeat_channel #(
            .BITS  (BITS),
            .TW    (TW),
            .ENV_W (ENV_W)
        ) u_ch (
            .dspclk      (dspclk),
            .n_reset     (n_reset),
            .sample_tick (sample_tick),
            .trig        (trig[c]),
            .mode        (mode[2*c +: 2]),
            .rate        (rate[4*c +: 4]),
            .decay       (decay[ENV_W*c +: ENV_W]),
            .mute        (mute[c]),
            .lfsr        (lfsr),
            .p           (p_all[c])
        );
    end

    always_comb begin
        sum = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) sum = sum + MW'(p_all[c]);
        sat = saturate(SAT_W'(sum), BITS, clipped);
    end

    assign unused_sat = ^(sat >> BITS);

    always_ff @(posedge dspclk or negedge n_reset) begin
        if (!n_reset) begin
            sig       <= '0;
            sig_valid <= 1'b0;
            clip      <= 1'b0;
        end else begin
            sig_valid <= tick_d2;
            clip      <= tick_d2 & clipped;
            if (tick_d2) sig <= sat[BITS-1:0];
        end
    end

endmodule

// File: tb/tb_bytebeat_mixer.sv
// Randomised and directed bench for bytebeat_mixer against a per-sample
// arithmetic model of the voices, envelopes, noise source and mixer.
module tb_bytebeat_mixer;

    localparam int unsigned BITS  = 16;
    localparam int unsigned CH    = 4;
    localparam int unsigned TW    = 32;
    localparam int unsigned ENV_W = 8;

    logic                   dspclk = 1'b0;
    logic                   n_reset;
    logic                   sample_tick;
    logic [CH-1:0]          trig;
    logic [2*CH-1:0]        mode;
    logic [4*CH-1:0]        rate;
    logic [ENV_W*CH-1:0]    decay;
    logic [CH-1:0]          mute;
    logic signed [BITS-1:0] sig;
    logic                   sig_valid;
    logic                   clip;

    bytebeat_mixer #(
        .BITS     (BITS),
        .CHANNELS (CH),
        .TW       (TW),
        .ENV_W    (ENV_W)
    ) dut (
        .dspclk      (dspclk),
        .n_reset     (n_reset),
        .sample_tick (sample_tick),
        .trig        (trig),
        .mode        (mode),
        .rate        (rate),
        .decay       (decay),
        .mute        (mute),
        .sig         (sig),
        .sig_valid   (sig_valid),
        .clip        (clip)
    );

    always #5 dspclk = ~dspclk;

    int checks = 0;
    int errors = 0;
    int dut_strobes = 0;

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: per-voice time and envelope, noise state, and the
    // sample expected on the output two edges after each tick.
    longint unsigned t_m [CH];
    longint          env_m [CH];
    logic [15:0]     lfsr_m;
    bit              tick_prev, tick_prev2;
    longint          pend_sig;
    bit              pend_clip;
    longint          exp_sig;
    bit              exp_clip, exp_valid;

    function automatic longint voice(input int c);
        longint unsigned tt, a, b;
        longint raw, s;
        if (mute[c]) return 0;
        tt = t_m[c];
        case (int'(mode[2*c +: 2]))
            0: raw = ((tt >> 11) & 1) != 0 ? (64'sd1 <<< BITS) - 1 : 0;
            1: raw = longint'((tt & 64'hFFF) << (BITS - 12));
            2: begin
                a = tt & 255;
                b = ((tt >> 8) | (tt >> 9)) & 255;
                raw = longint'(((a * b) % 256) << (BITS - 8));
            end
            default: raw = longint'(lfsr_m) <<< (BITS - 16);
        endcase
        s = raw - (64'sd1 <<< (BITS - 1));
        return (s * env_m[c]) >>> ENV_W;
    endfunction

    task automatic mix_pending();
        longint sum, lo, hi;
        sum = 0;
        for (int c = 0; c < CH; c++) sum += voice(c);
        lo = -(64'sd1 <<< (BITS - 1));
        hi = -lo - 1;
        pend_clip = (sum > hi) || (sum < lo);
        pend_sig  = sum > hi ? hi : (sum < lo ? lo : sum);
    endtask

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            t_m[c] = 0;
            env_m[c] = 0;
        end
        lfsr_m = 16'hACE1;
        tick_prev = 0;
        tick_prev2 = 0;
        exp_sig = 0;
        exp_clip = 0;
        exp_valid = 0;
    endtask

    task automatic model_edge();
        longint e;
        longint unsigned mask;
        if (!n_reset) begin
            model_reset();
            return;
        end
        mask = (64'd1 << TW) - 1;
        exp_valid = tick_prev2;
        exp_clip  = tick_prev2 ? pend_clip : 1'b0;
        if (tick_prev2) exp_sig = pend_sig;
        if (tick_prev) mix_pending();
        tick_prev2 = tick_prev;
        tick_prev  = sample_tick;
        for (int c = 0; c < CH; c++) begin
            if (trig[c]) begin
                t_m[c] = 0;
                env_m[c] = (1 << ENV_W) - 1;
            end else if (sample_tick) begin
                t_m[c] = (t_m[c] + rate[4*c +: 4] + 1) & mask;
                e = env_m[c] - longint'(decay[ENV_W*c +: ENV_W]);
                env_m[c] = e < 0 ? 0 : e;
            end
        end
        if (sample_tick) lfsr_m = (lfsr_m >> 1) ^ (lfsr_m[0] ? 16'hB400 : 16'h0000);
    endtask

    task automatic cycle();
        @(posedge dspclk);
        model_edge();
        #1;
        if (sig_valid === 1'b1) dut_strobes++;
        check("sig_valid", sig_valid, exp_valid);
        check("sig", sig, exp_sig);
        check("clip", clip, exp_clip);
    endtask

    task automatic set_ch(input int c, input int md, input int rt, input int dc, input bit mu);
        mode[2*c +: 2]          = md[1:0];
        rate[4*c +: 4]          = rt[3:0];
        decay[ENV_W*c +: ENV_W] = dc[ENV_W-1:0];
        mute[c]                 = mu;
    endtask

    task automatic solo_ch0(input int md, input int rt, input int dc);
        set_ch(0, md, rt, dc, 1'b0);
        for (int c = 1; c < CH; c++) set_ch(c, 0, 0, 0, 1'b1);
    endtask

    initial begin
        n_reset = 1'b0;
        sample_tick = 1'b0;
        trig = '0;
        mode = '0;
        rate = '0;
        decay = '0;
        mute = '0;
        model_reset();
        pend_sig = 0;
        pend_clip = 0;

        // Reset held with ticks, then ten silent ticks.
        sample_tick = 1'b1;
        for (int i = 0; i < 5; i++) cycle();
        n_reset = 1'b1;
        dut_strobes = 0;
        for (int i = 0; i < 10; i++) cycle();
        sample_tick = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        check("silent_strobes", dut_strobes, 10);

        // Saw voice, one tick after trigger.
        solo_ch0(1, 0, 0);
        trig[0] = 1'b1; cycle();
        trig[0] = 1'b0; sample_tick = 1'b1; cycle();
        sample_tick = 1'b0; cycle(); cycle();
        check("saw_sig", sig, -32625);

        // Envelope decays by one per tick and sticks at zero.
        solo_ch0(0, 0, 1);
        trig[0] = 1'b1; cycle();
        trig[0] = 1'b0; sample_tick = 1'b1;
        for (int i = 0; i < 300; i++) cycle();
        sample_tick = 1'b0; cycle(); cycle();
        check("decay_sig", sig, 0);

        // Four full-scale squares saturate both ways.
        for (int c = 0; c < CH; c++) set_ch(c, 0, 15, 0, 1'b0);
        trig = '1; cycle();
        trig = '0; sample_tick = 1'b1;
        for (int i = 0; i < 128; i++) cycle();
        sample_tick = 1'b0; cycle(); cycle();
        check("sat_hi_sig", sig, 32767);
        check("sat_hi_clip", clip, 1);
        trig = '1; cycle();
        trig = '0; sample_tick = 1'b1; cycle();
        sample_tick = 1'b0; cycle(); cycle();
        check("sat_lo_sig", sig, -32768);
        check("sat_lo_clip", clip, 1);

        // Trigger wins over a simultaneous tick.
        solo_ch0(1, 0, 0);
        trig[0] = 1'b1; sample_tick = 1'b1; cycle();
        trig[0] = 1'b0; sample_tick = 1'b0; cycle(); cycle();
        check("trig_tick_sig", sig, -32640);

        // Noise after reset: first tick moves the LFSR to E270.
        n_reset = 1'b0; cycle();
        n_reset = 1'b1;
        solo_ch0(3, 0, 0);
        trig[0] = 1'b1; cycle();
        trig[0] = 1'b0; sample_tick = 1'b1; cycle();
        sample_tick = 1'b0; cycle(); cycle();
        check("noise_sig", sig, 25101);

        // Asynchronous reset between a tick and its strobe.
        trig[0] = 1'b1; cycle();
        trig[0] = 1'b0; sample_tick = 1'b1; cycle();
        sample_tick = 1'b0;
        #2 n_reset = 1'b0;
        #1;
        check("async_sig", sig, 0);
        check("async_valid", sig_valid, 0);
        model_reset();
        cycle();
        n_reset = 1'b1;
        dut_strobes = 0;
        for (int i = 0; i < 3; i++) cycle();
        check("async_no_strobe", dut_strobes, 0);
        sample_tick = 1'b1; cycle();
        sample_tick = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        check("async_after_strobes", dut_strobes, 1);

        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            sample_tick = ($urandom_range(0, 2) != 0);
            for (int c = 0; c < CH; c++) begin
                trig[c] = ($urandom_range(0, 31) == 0);
                if ($urandom_range(0, 15) == 0)
                    set_ch(c, int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
                           int'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0));
            end
            cycle();
        end
        trig = '0;
        sample_tick = 1'b0;
        for (int i = 0; i < 3; i++) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
